mdio_arbiter: RTL

Round-robin arbiter sharing one `mdio_master` command/response interface among `N_REQ` requesters, e.g. the PHY configuration sequencer and a periodic link-status poller. It grants one requester at a time and passes its command through to the master. For read opcodes it holds the grant until read data returns, then routes that data back to the same requester. It sits between the requesters and the single `mdio_master` instance that drives `mdc` and `mdio`.

---
 rtl/mdio_arbiter_pkg.sv | 16 +
 rtl/mdio_arbiter_if.sv | 41 ++++
 rtl/mdio_arbiter_rr_pick.sv | 26 ++
 rtl/mdio_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mdio_arbiter_pkg.sv
// Shared types and constants for the MDIO command arbiter.
// Optional read-response watchdog is enabled by defining MDIO_ARB_TIMEOUT_EN.
package mdio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WAIT_RSP = 2'd2,
    RSP      = 2'd3
  } state_t;

  localparam logic [1:0]  OP_WRITE         = 2'b01;
  localparam logic [1:0]  OP_READ          = 2'b10;
  localparam logic [15:0] RSP_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/mdio_arbiter_if.sv
// Requester and mdio_master command/response signals of the arbiter.
// master modport is the arbiter's view, slave modport is the surrounding logic.
interface mdio_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [5*N_REQ-1:0]  req_phy_addr;
  logic [5*N_REQ-1:0]  req_reg_addr;
  logic [16*N_REQ-1:0] req_data;
  logic [2*N_REQ-1:0]  req_opcode;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [15:0]         rsp_data;
  logic                rsp_err;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [4:0]          m_cmd_phy_addr;
  logic [4:0]          m_cmd_reg_addr;
  logic [15:0]         m_cmd_data;
  logic [1:0]          m_cmd_opcode;
  logic                m_cmd_valid;
  logic                m_cmd_ready;
  logic [15:0]         m_data_out;
  logic                m_data_out_valid;
  logic                m_data_out_ready;

  modport master (
    input  req_phy_addr, req_reg_addr, req_data, req_opcode, req_valid, rsp_ready,
           m_cmd_ready, m_data_out, m_data_out_valid,
    output req_ready, rsp_data, rsp_err, rsp_valid,
           m_cmd_phy_addr, m_cmd_reg_addr, m_cmd_data, m_cmd_opcode, m_cmd_valid,
           m_data_out_ready
  );

  modport slave (
    output req_phy_addr, req_reg_addr, req_data, req_opcode, req_valid, rsp_ready,
           m_cmd_ready, m_data_out, m_data_out_valid,
    input  req_ready, rsp_data, rsp_err, rsp_valid,
           m_cmd_phy_addr, m_cmd_reg_addr, m_cmd_data, m_cmd_opcode, m_cmd_valid,
           m_data_out_ready
  );
endinterface

// File: rtl/mdio_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit after 'last', wrapping; latency 0.
// Purely combinational, no backpressure.
module mdio_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] pos;

  // Walk from the farthest candidate back to last+1 so the nearest set bit wins.
  always_comb begin
    valid = |req;
    index = last;
    pos   = last;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = IDX_W'((int'(last) + k) % N_REQ);
      if (req[pos]) index = pos;
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter in front of one mdio_master; cmd 1 cycle after req_valid in IDLE, rsp 1 cycle after read data.
// Backpressure: req_ready follows m_cmd_ready for the owner; reads hold the grant until rsp_ready. Option: MDIO_ARB_TIMEOUT_EN.
module mdio_arbiter
  import mdio_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  mdio_arbiter_if.master   bus,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("mdio_arbiter: unsupported parameter values");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q;
  logic             rsp_err_q, rsp_err_d;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] rsp_valid;
  logic             m_cmd_valid;
  logic             m_data_out_ready;
  logic [4:0]       cmd_phy;
  logic [4:0]       cmd_reg;
  logic [15:0]      cmd_data;
  logic [1:0]       cmd_op;
  logic             timeout_hit;

  mdio_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req_valid),
    .last  (last_q),
    .valid (pick_vld),
    .index (pick_idx)
  );

  always_comb begin
    cmd_phy  = '0;
    cmd_reg  = '0;
    cmd_data = '0;
    cmd_op   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q == IDX_W'(i)) begin
        cmd_phy  = bus.req_phy_addr[5*i +: 5];
        cmd_reg  = bus.req_reg_addr[5*i +: 5];
        cmd_data = bus.req_data[16*i +: 16];
        cmd_op   = bus.req_opcode[2*i +: 2];
      end
    end
  end

`ifdef MDIO_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= (state_q == WAIT_RSP) ? to_cnt_q + 1'b1 : '0;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign timeout_hit = (state_q == WAIT_RSP) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_q   = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    gnt_d            = gnt_q;
    rsp_data_d       = rsp_data_q;
    rsp_err_d        = rsp_err_q;
    m_cmd_valid      = 1'b0;
    req_ready        = '0;
    rsp_valid        = '0;
    m_data_out_ready = 1'b1;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          state_d = CMD;
        end
      end
      CMD: begin
        m_cmd_valid      = 1'b1;
        req_ready[gnt_q] = bus.m_cmd_ready;
        if (bus.m_cmd_ready) begin
          if (cmd_op == OP_READ) begin
            state_d = WAIT_RSP;
          end else begin
            last_d  = gnt_q;
            state_d = IDLE;
          end
        end else if (!bus.req_valid[gnt_q]) begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        if (bus.m_data_out_valid) begin
          rsp_data_d = bus.m_data_out;
          rsp_err_d  = 1'b0;
          state_d    = RSP;
        end else if (timeout_hit) begin
          rsp_data_d = RSP_TIMEOUT_DATA;
          rsp_err_d  = 1'b1;
          state_d    = RSP;
        end
      end
      RSP: begin
        m_data_out_ready = 1'b0;
        rsp_valid[gnt_q] = 1'b1;
        if (bus.rsp_ready[gnt_q]) begin
          last_d    = gnt_q;
          rsp_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant/busy are registered from the next state so they line up with state_q.
  always_comb begin
    grant_d = '0;
    if (state_d != IDLE) grant_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(N_REQ - 1);
      gnt_q      <= '0;
      rsp_data_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      rsp_data_q <= rsp_data_d;
      grant_q    <= grant_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.req_ready        = req_ready;
  assign bus.rsp_valid        = rsp_valid;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.m_cmd_valid      = m_cmd_valid;
  assign bus.m_cmd_phy_addr   = cmd_phy;
  assign bus.m_cmd_reg_addr   = cmd_reg;
  assign bus.m_cmd_data       = cmd_data;
  assign bus.m_cmd_opcode     = cmd_op;
  assign bus.m_data_out_ready = m_data_out_ready;
  assign grant                = grant_q;
  assign busy                 = busy_q;

endmodule
